// File: rtl/tc77_responder.sv
`default_nettype none
//============================================================================
// Module      : tc77_responder
// Description : Slave-side model of the TC77 SPI temperature sensor.
//               Free-running conversion timer, 16-bit read word
//               {TEMP[12:0], conversion-complete, 2 x Hi-Z} shifted out
//               MSB-first on SIO, followed by a 16-bit configuration write
//               (0xFFFF = shutdown, 0x0000 = continuous conversion).
//               SIO is split into SIO_I / SIO_O / SIO_OE; the board top
//               resolves these onto the bidirectional pin.
// Revision    : 1.0 - initial release
//============================================================================
module tc77_responder #(
    parameter logic [23:0] CONV_CYCLES = 24'd1000   // MCLK cycles per conversion, >= 2
) (
    input  logic        MCLK,        // single clock
    input  logic        RESET,       // synchronous, active-high
    input  logic [12:0] TEMP_VALUE,  // two's complement, 0.0625 C/LSB
    input  logic        nTEMPCS,     // chip select, asynchronous, active-low
    input  logic        TEMPCLK,     // SCK, asynchronous, idle low
    input  logic        SIO_I,       // SIO pin input
    output logic        SIO_O,       // SIO output data
    output logic        SIO_OE,      // SIO output enable (0 = Hi-Z)
    output logic        CONV_DONE,   // first conversion since reset completed
    output logic        SHUTDOWN     // configuration register holds 16'hFFFF
);

    // Transaction states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0]  RISE_READ_END  = 6'd16;
    localparam logic [5:0]  RISE_WRITE_END = 6'd32;
    localparam logic [3:0]  LAST_DRIVEN    = 4'd13;
    localparam logic [15:0] CFG_SHUTDOWN   = 16'hFFFF;
    localparam logic [15:0] CFG_CONTINUOUS = 16'h0000;

    // ------------------------------------------------------------------
    // Synchronisers and edge detectors
    // ------------------------------------------------------------------
    logic cs_s1, cs_s2, cs_d;
    logic sck_s1, sck_s2, sck_d;
    logic sio_s1, sio_s2;

    logic cs_fall, cs_rise;
    logic sck_fall, sck_rise;

    // Two-stage synchronisers plus one delay stage for edge detection.
    // CS resets to its idle (high) level so that a release of reset with
    // CS already high produces no spurious edge.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            cs_d   <= 1'b1;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_d  <= 1'b0;
            sio_s1 <= 1'b0;
            sio_s2 <= 1'b0;
        end else begin
            cs_s1  <= nTEMPCS;
            cs_s2  <= cs_s1;
            cs_d   <= cs_s2;
            sck_s1 <= TEMPCLK;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            sio_s1 <= SIO_I;
            sio_s2 <= sio_s1;
        end
    end

    assign cs_fall  =  cs_d  & ~cs_s2;
    assign cs_rise  = ~cs_d  &  cs_s2;
    assign sck_rise = ~sck_d &  sck_s2;
    assign sck_fall =  sck_d & ~sck_s2;

    // ------------------------------------------------------------------
    // Transaction datapath registers
    // ------------------------------------------------------------------
    logic [1:0]  state, state_next;
    logic [15:0] shreg;
    logic [15:0] cfg_sh;
    logic [3:0]  bitidx;
    logic [5:0]  rcnt;
    logic [12:0] temp_reg;
    logic [23:0] timer;

    logic [3:0]  bitidx_inc;
    logic [5:0]  rcnt_inc;
    logic [15:0] load_word;

    // Both counters saturate so stray extra edges cannot wrap them
    assign bitidx_inc = (bitidx == 4'd15) ? 4'd15 : bitidx + 4'd1;
    assign rcnt_inc   = (rcnt == RISE_WRITE_END) ? RISE_WRITE_END : rcnt + 6'd1;

    // Word captured at CS fall uses register values from before this edge,
    // so a same-cycle conversion completion is not visible in this read.
    assign load_word  = {temp_reg, CONV_DONE, 2'b00};

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; CS rise aborts READ/WRITE and commits from DONE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (sck_rise && (rcnt_inc == RISE_READ_END)) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (sck_rise && (rcnt_inc == RISE_WRITE_END)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic do_load;     // capture read word, start driving bit 15
    logic do_step;     // advance to next output bit on SCK fall
    logic do_count;    // count an SCK rising edge
    logic do_oe_off;   // read phase finished, release SIO
    logic do_shift_in; // shift one configuration bit in
    logic do_abort;    // CS released before the write completed
    logic do_commit;   // CS released after a complete write

    // Output/action decode from the current state and synchronised edges
    always_comb begin
        do_load     = 1'b0;
        do_step     = 1'b0;
        do_count    = 1'b0;
        do_oe_off   = 1'b0;
        do_shift_in = 1'b0;
        do_abort    = 1'b0;
        do_commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                do_load = cs_fall;
            end
            ST_READ: begin
                if (cs_rise) begin
                    do_abort = 1'b1;
                end else begin
                    do_step   = sck_fall;
                    do_count  = sck_rise;
                    do_oe_off = sck_rise && (rcnt_inc == RISE_READ_END);
                end
            end
            ST_WRITE: begin
                if (cs_rise) begin
                    do_abort = 1'b1;
                end else begin
                    do_count    = sck_rise;
                    do_shift_in = sck_rise;
                end
            end
            ST_DONE: begin
                do_commit = cs_rise;
            end
            default: begin
                do_abort = 1'b0;
            end
        endcase
    end

    // A committed 0x0000 restarts the conversion timer from zero
    logic cfg_clear;
    assign cfg_clear = do_commit && (cfg_sh == CFG_CONTINUOUS);

    // Shift registers, bit counters, SIO drive and configuration register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            shreg    <= 16'h0000;
            cfg_sh   <= 16'h0000;
            bitidx   <= 4'd0;
            rcnt     <= 6'd0;
            SIO_O    <= 1'b0;
            SIO_OE   <= 1'b0;
            SHUTDOWN <= 1'b0;
        end else begin
            if (do_load) begin
                shreg  <= load_word;
                cfg_sh <= 16'h0000;
                bitidx <= 4'd0;
                rcnt   <= 6'd0;
                SIO_O  <= load_word[15];
                SIO_OE <= 1'b1;
            end
            if (do_step) begin
                bitidx <= bitidx_inc;
                SIO_O  <= shreg[4'd15 - bitidx_inc];
                // Bits 1:0 of the word are never driven
                SIO_OE <= (bitidx_inc <= LAST_DRIVEN);
            end
            if (do_count) begin
                rcnt <= rcnt_inc;
            end
            if (do_oe_off || do_abort) begin
                SIO_OE <= 1'b0;
            end
            if (do_shift_in) begin
                cfg_sh <= {cfg_sh[14:0], sio_s2};
            end
            if (do_commit) begin
                if (cfg_sh == CFG_SHUTDOWN) begin
                    SHUTDOWN <= 1'b1;
                end else if (cfg_sh == CFG_CONTINUOUS) begin
                    SHUTDOWN <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion timer
    // ------------------------------------------------------------------
    logic conv_tick;
    assign conv_tick = (timer == (CONV_CYCLES - 24'd1));

    // Free-running 0..CONV_CYCLES-1 counter; parked at zero in shutdown.
    // A config clear takes priority over a coincident conversion.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            timer     <= 24'd0;
            temp_reg  <= 13'd0;
            CONV_DONE <= 1'b0;
        end else if (cfg_clear || SHUTDOWN) begin
            timer <= 24'd0;
        end else if (conv_tick) begin
            timer     <= 24'd0;
            temp_reg  <= TEMP_VALUE;
            CONV_DONE <= 1'b1;
        end else begin
            timer <= timer + 24'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc77_responder.sv
`default_nettype none
//============================================================================
// Module      : tb_tc77_responder
// Description : Directed self-checking bench for tc77_responder with
//               CONV_CYCLES = 100. Acts as the SPI master: SCK phases of
//               5 MCLK, SIO sampled at each SCK rise, config bits driven
//               after each SCK fall.
// Revision    : 1.0 - initial release
//============================================================================
module tb_tc77_responder;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic [12:0] TEMP_VALUE;
    logic        nTEMPCS;
    logic        TEMPCLK;
    logic        SIO_I;
    logic        SIO_O;
    logic        SIO_OE;
    logic        CONV_DONE;
    logic        SHUTDOWN;

    int total = 0;
    int bad   = 0;

    logic [15:0] rd;
    logic [15:0] oe;

    always #5 MCLK = ~MCLK;

    tc77_responder #(.CONV_CYCLES(24'd100)) dut (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .TEMP_VALUE (TEMP_VALUE),
        .nTEMPCS    (nTEMPCS),
        .TEMPCLK    (TEMPCLK),
        .SIO_I      (SIO_I),
        .SIO_O      (SIO_O),
        .SIO_OE     (SIO_OE),
        .CONV_DONE  (CONV_DONE),
        .SHUTDOWN   (SHUTDOWN)
    );

    // Advance n MCLK edges and land 1 ns after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lower CS and run nrise SCK pulses; CS is left low
    task automatic xfer(input logic [15:0] wr, input int nrise,
                        output logic [15:0] rdw, output logic [15:0] oew);
        rdw     = 16'h0000;
        oew     = 16'h0000;
        SIO_I   = 1'b0;
        nTEMPCS = 1'b0;
        cyc(5);
        for (int r = 1; r <= nrise; r++) begin
            if (r <= 16) begin
                rdw[16-r] = SIO_O;
                oew[16-r] = SIO_OE;
            end
            TEMPCLK = 1'b1;
            cyc(5);
            TEMPCLK = 1'b0;
            if (r >= 16 && r <= 31) SIO_I = wr[31-r];
            cyc(5);
        end
    endtask

    task automatic cs_up(input int n);
        nTEMPCS = 1'b1;
        SIO_I   = 1'b0;
        cyc(n);
    endtask

    // 16-clock read then abort; checks driven mask and driven data
    task automatic read_chk(input string tag, input logic [15:0] exp);
        logic [15:0] r_w;
        logic [15:0] o_w;
        xfer(16'h0000, 16, r_w, o_w);
        cs_up(5);
        chk({tag, "_oe"}, {16'h0, o_w}, {16'h0, 16'hFFFC});
        chk(tag, {16'h0, r_w & 16'hFFFC}, {16'h0, exp});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET      = 1'b1;
        nTEMPCS    = 1'b1;
        TEMPCLK    = 1'b0;
        SIO_I      = 1'b0;
        TEMP_VALUE = 13'h0190;
        cyc(3);

        // Reset values
        chk("rst_sio_o",    {31'h0, SIO_O},     32'h0);
        chk("rst_sio_oe",   {31'h0, SIO_OE},    32'h0);
        chk("rst_conv",     {31'h0, CONV_DONE}, 32'h0);
        chk("rst_shutdown", {31'h0, SHUTDOWN},  32'h0);

        // First conversion completes at the 100th edge after release
        RESET = 1'b0;
        cyc(99);
        chk("conv_edge99",  {31'h0, CONV_DONE}, 32'h0);
        cyc(1);
        chk("conv_edge100", {31'h0, CONV_DONE}, 32'h1);

        RESET = 1'b1;
        cyc(2);
        chk("rerst_conv", {31'h0, CONV_DONE}, 32'h0);
        RESET = 1'b0;
        cyc(2);

        // Test 1: read before and after the first conversion
        read_chk("t1_pre", 16'h0000);
        cyc(5);
        read_chk("t1_post", 16'h0C84);
        chk("t1_conv", {31'h0, CONV_DONE}, 32'h1);

        // Test 2: negative temperature
        TEMP_VALUE = 13'h1F60;
        cyc(110);
        read_chk("t2_neg", 16'hFB04);

        // SCK toggling with CS high is ignored
        for (int i = 0; i < 3; i++) begin
            TEMPCLK = 1'b1;
            cyc(5);
            TEMPCLK = 1'b0;
            cyc(5);
        end
        chk("sck_cs_high_oe", {31'h0, SIO_OE}, 32'h0);

        // Test 3/5: shutdown holds the old reading; 0x1234 leaves it on
        xfer(16'hFFFF, 32, rd, oe);
        cs_up(5);
        chk("t3_shutdown_on", {31'h0, SHUTDOWN}, 32'h1);
        TEMP_VALUE = 13'h0123;
        cyc(5);
        xfer(16'h1234, 32, rd, oe);
        cs_up(5);
        chk("t5_sd_rd", {16'h0, rd & 16'hFFFC}, {16'h0, 16'hFB04});
        chk("t5_sd_keep", {31'h0, SHUTDOWN}, 32'h1);
        cyc(100);
        read_chk("t3_hold", 16'hFB04);
        xfer(16'h0000, 32, rd, oe);
        chk("t3_wr0_rd", {16'h0, rd & 16'hFFFC}, {16'h0, 16'hFB04});
        nTEMPCS = 1'b1;
        cyc(5);
        chk("t3_shutdown_off", {31'h0, SHUTDOWN}, 32'h0);
        cyc(90);
        read_chk("t3_before", 16'hFB04);
        cyc(5);
        read_chk("t3_after", 16'h091C);

        // Test 4: aborted write, then abort during read
        xfer(16'hFFFF, 20, rd, oe);
        nTEMPCS = 1'b1;
        cyc(3);
        chk("t4_abort_oe", {31'h0, SIO_OE}, 32'h0);
        cyc(5);
        chk("t4_shutdown", {31'h0, SHUTDOWN}, 32'h0);
        xfer(16'h0000, 5, rd, oe);
        chk("t4_rd_oe_on", {31'h0, SIO_OE}, 32'h1);
        nTEMPCS = 1'b1;
        cyc(3);
        chk("t4_rd_oe_off", {31'h0, SIO_OE}, 32'h0);
        cyc(5);
        read_chk("t4_next", 16'h091C);

        // Test 5: 0x1234 while running leaves SHUTDOWN low
        xfer(16'h1234, 32, rd, oe);
        cs_up(8);
        chk("t5_rd", {16'h0, rd & 16'hFFFC}, {16'h0, 16'h091C});
        chk("t5_shutdown", {31'h0, SHUTDOWN}, 32'h0);

        // Test 6: reset at SCK falling edge 7
        nTEMPCS = 1'b0;
        cyc(5);
        for (int r = 1; r <= 7; r++) begin
            TEMPCLK = 1'b1;
            cyc(5);
            if (r == 7) begin
                chk("t6_oe_before", {31'h0, SIO_OE}, 32'h1);
                chk("t6_conv_before", {31'h0, CONV_DONE}, 32'h1);
                TEMPCLK = 1'b0;
                RESET   = 1'b1;
                cyc(1);
            end else begin
                TEMPCLK = 1'b0;
                cyc(5);
            end
        end
        chk("t6_oe", {31'h0, SIO_OE}, 32'h0);
        chk("t6_conv", {31'h0, CONV_DONE}, 32'h0);
        RESET   = 1'b0;
        nTEMPCS = 1'b1;
        cyc(5);
        read_chk("t6_after", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc77_responder.md
# tc77_responder

Synthesizable slave-side model of the TC77 SPI temperature sensor, the responder to the TC77 read/config master that the temperature-sense controller uses. It runs a free-running conversion timer, presents `{TEMP[12:0], conversion-complete flag, 2 × Hi-Z}` MSB-first on the shared SIO line, and accepts the 16-bit configuration write (continuous/shutdown) that follows the read. It sits on the emulation board and in bench tops in place of the physical sensor. The top level resolves SIO into the inout pin.

## Interface

Parameters:
- `CONV_CYCLES`, default 24'd1000: MCLK cycles per conversion. Legal range is 2 or more.

Ports:
- `MCLK` in 1: the single clock.
- `RESET` in 1: reset, synchronous and active-high.
- `TEMP_VALUE` in 13: two's-complement temperature at 0.0625 °C/LSB. Sampled only at conversion completion.
- `nTEMPCS` in 1: chip select from the master, asynchronous to MCLK.
- `TEMPCLK` in 1: SCK from the master, asynchronous to MCLK, idle low.
- `SIO_I` in 1: SIO pin input.
- `SIO_O` out 1: SIO output data.
- `SIO_OE` out 1: SIO output enable. When 0, SIO is Hi-Z.
- `CONV_DONE` out 1: high once the first conversion since reset has completed.
- `SHUTDOWN` out 1: high while the config register holds 16'hFFFF.

## Operation

- **Input synchronisation.** `nTEMPCS` and `TEMPCLK` each pass through a 2-FF synchroniser, then a delay FF for edge detection. `SIO_I` is also 2-FF synchronised. Every protocol action in this block uses the synchronised signals.
- **Conversion timer.**
  - A 24-bit counter runs 0..`CONV_CYCLES`-1 and wraps.
  - On the terminal count the block sets `temp_reg <= TEMP_VALUE` and `CONV_DONE <= 1`.
  - During shutdown the counter is held at 0, and `temp_reg` and `CONV_DONE` keep their values.
- **Transaction states:** IDLE, READ, WRITE, DONE.
  - **IDLE:**
    - `SIO_OE` = 0.
    - On CS falling edge, load `shreg <= {temp_reg, CONV_DONE, 2'b00}` (values before any same-cycle conversion update).
    - Set `bitidx <= 0`, `SIO_O <= shreg[15]`, `SIO_OE <= 1`, then go to READ.
  - **READ:**
    - On each SCK falling edge: `bitidx++`, `SIO_O <= word[15-bitidx]`, `SIO_OE <= (bitidx <= 13)`.
    - SCK rising edges are counted in `rcnt`. When the 16th rising edge arrives, set `SIO_OE <= 0` and go to WRITE.
  - **WRITE:**
    - `SIO_OE` = 0.
    - On rising edges 17..32, shift `SIO_I` into `cfg_sh` MSB-first.
    - After the 32nd rising edge, go to DONE.
  - **DONE:**
    - Further SCK edges are ignored.
    - On CS rising edge: if `cfg_sh` = 16'hFFFF, set `SHUTDOWN <= 1`. If `cfg_sh` = 16'h0000, set `SHUTDOWN <= 0` and clear the conversion timer to 0. Any other value leaves config unchanged.
- **Early CS deassertion.** A CS rising edge in READ or WRITE aborts the transaction:
  - `SIO_OE <= 0` and the state returns to IDLE.
  - Config is unchanged and the partial write is discarded.
- **Counter widths.** `bitidx` is 4 bits and saturates at 15. `rcnt` is 6 bits and saturates at 32.

## Timing

- **Reset values.** `SIO_O` = 0, `SIO_OE` = 0, `CONV_DONE` = 0, `SHUTDOWN` = 0. Internally: `temp_reg` = 0, timer = 0, state = IDLE.
- **Reset mid-transaction** gives the same values on the next edge. The master sees Hi-Z.
- **First conversion.** `CONV_DONE` rises at the MCLK edge ending cycle `CONV_CYCLES` after `RESET` is released. Subsequent conversions follow every `CONV_CYCLES` cycles.
- **Output latency.** `SIO_O`/`SIO_OE` update 3 MCLK after the raw CS falling edge or SCK falling edge (2 sync + 1 register).
- **Input requirements.**
  - SCK high and low phases must each be at least 4 MCLK cycles.
  - CS setup to the first SCK rise must be at least 4 MCLK cycles.
  - The master samples SIO on the SCK rising edge.
- **Simultaneous events.**
  - Conversion completion in the same cycle as a CS falling edge: the shift register loads the old value.
  - Conversion completion during a transaction never alters the word being shifted.
  - Conversion completion in the same cycle as a CS rising edge that commits 0x0000: the timer clear wins.
- **SCK with CS high** is ignored.

## Test plan

1. `CONV_CYCLES`=100, `TEMP_VALUE`=13'h0190 (+25 °C); run a read before cycle 100. The read returns `{13'h0000, 0}` and `SIO_OE` is 0 for bits 1:0. A read after cycle 101 returns `{13'h0190, 1}` = 16'h0C84 on the driven bits.
2. `TEMP_VALUE`=13'h1F60 (−10 °C) after the first conversion. The 14 driven bits = 14'h3EC1 and `CONV_DONE`=1.
3. Full 32-clock transaction writing 16'hFFFF → `SHUTDOWN`=1. Then change `TEMP_VALUE`: repeated reads keep returning the old value for more than 3×`CONV_CYCLES`. Write 16'h0000 → `SHUTDOWN`=0, and the new value appears exactly `CONV_CYCLES` cycles after the CS rise.
4. CS raised after 20 SCK rises while writing 16'hFFFF → `SHUTDOWN` stays 0 and `SIO_OE`=0 within 3 MCLK. The next transaction starts clean from bit 15.
5. Write of 16'h1234 → config is unchanged and `SHUTDOWN` is unchanged.
6. `RESET` asserted at SCK falling edge #7 → the next MCLK gives `SIO_OE`=0 and `CONV_DONE`=0. The following transaction returns 16'h0000 on the driven bits.
